hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core.
- Generates per-stage stall and flush (bubble) controls for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Sources of stalls and flushes: load-use hazards the EXE forwarding path cannot cover (load sitting in EXE/MEM), multi-cycle data-memory accesses, the multi-cycle MUL/DIV unit, and taken-branch redirects.
- Sits beside the forwarding logic, watching the same ID/EXE and EXE/MEM register fields.

---
 rtl/hazard_ctrl_if.sv | 68 ++++++
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard bus between the core datapath and hazard_ctrl
//
// Purpose: carries the ID/EXE and EXE/MEM register fields, memory/MDU/branch
// status, and the per-stage stall/flush controls returned by hazard_ctrl.
// Modports:
//   master - pipeline side: drives hazard sources, receives controls.
//   slave  - hazard_ctrl side: receives hazard sources, drives controls.
// perf_stall_cycles/perf_flush_cnt always exist; they read 0 unless the
// controller is built with HAZARD_PERF_CNT_EN.

`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif
`ifndef On
`define On 1'b1
`endif
`ifndef Off
`define Off 1'b0
`endif

interface hazard_ctrl_if;
  logic [`GPR_ADDR_SPACE] id_exe_rs1_addr;
  logic                   id_exe_rs1_re;
  logic [`GPR_ADDR_SPACE] id_exe_rs2_addr;
  logic                   id_exe_rs2_re;
  logic [`GPR_ADDR_SPACE] exe_mem_rd_addr;
  logic                   exe_mem_rd_we;
  logic                   exe_mem_mem_re;
  logic                   dmem_req;
  logic                   dmem_ack;
  logic                   exe_mdu_start;
  logic                   mdu_done;
  logic                   exe_branch_taken;

  logic                   pc_stall;
  logic                   if_id_stall;
  logic                   id_exe_stall;
  logic                   exe_mem_stall;
  logic                   exe_mem_flush;
  logic                   mem_wb_flush;
  logic                   if_id_flush;
  logic                   id_exe_flush;
  logic                   pc_redirect;
  logic [1:0]             ctrl_state;
  logic                   mem_timeout;
  logic [31:0]            perf_stall_cycles;
  logic [31:0]            perf_flush_cnt;

  modport master (
    output id_exe_rs1_addr, id_exe_rs1_re, id_exe_rs2_addr, id_exe_rs2_re,
           exe_mem_rd_addr, exe_mem_rd_we, exe_mem_mem_re,
           dmem_req, dmem_ack, exe_mdu_start, mdu_done, exe_branch_taken,
    input  pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
           exe_mem_flush, mem_wb_flush, if_id_flush, id_exe_flush,
           pc_redirect, ctrl_state, mem_timeout,
           perf_stall_cycles, perf_flush_cnt
  );

  modport slave (
    input  id_exe_rs1_addr, id_exe_rs1_re, id_exe_rs2_addr, id_exe_rs2_re,
           exe_mem_rd_addr, exe_mem_rd_we, exe_mem_mem_re,
           dmem_req, dmem_ack, exe_mdu_start, mdu_done, exe_branch_taken,
    output pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
           exe_mem_flush, mem_wb_flush, if_id_flush, id_exe_flush,
           pc_redirect, ctrl_state, mem_timeout,
           perf_stall_cycles, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush sequencing controller
//
// Purpose: produces per-stage stall and flush controls from load-use hazards,
// multi-cycle data-memory accesses, the multi-cycle MUL/DIV unit and taken
// branches. Priority: memory wait > MUL/DIV > load-use > branch redirect.
// Ports:
//   clk   - core clock, rising edge.
//   rst_n - asynchronous active-low reset; also forces every control output
//           off while asserted.
//   bus   - hazard_ctrl_if.slave: hazard sources in, stage controls out,
//           ctrl_state (RUN=0, MEM_WAIT=1, MDU_BUSY=2), sticky mem_timeout.
// Parameters: MEM_TIMEOUT (memory wait cycles before mem_timeout),
//             CNT_W (wait counter width, must hold MEM_TIMEOUT).
// Optional: HAZARD_PERF_CNT_EN enables the perf_stall_cycles/perf_flush_cnt
//           counters; otherwise those outputs are tied to 0.

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MEM_TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   wait_cnt_inc;
  logic             timeout_q;

  logic mem_stall;
  logic mdu_stall;
  logic load_use;
  logic any_stall;
  logic redirect;
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = bus.id_exe_rs1_re && (bus.id_exe_rs1_addr == bus.exe_mem_rd_addr);
  assign rs2_hit = bus.id_exe_rs2_re && (bus.id_exe_rs2_addr == bus.exe_mem_rd_addr);

  // Next state and hazard classification
  always_comb begin
    state_nxt = state;
    mem_stall = bus.dmem_req && !bus.dmem_ack;
    mdu_stall = 1'b0;
    load_use  = 1'b0;

    // An MDU op only starts stalling from RUN when memory is not already
    // holding the pipe; once busy it stalls until done regardless.
    if (state == RUN)
      mdu_stall = !mem_stall && bus.exe_mdu_start && !bus.mdu_done;
    else if (state == MDU_BUSY)
      mdu_stall = !bus.mdu_done;

    if (!mem_stall && !mdu_stall)
      load_use = bus.exe_mem_mem_re && bus.exe_mem_rd_we &&
                 (bus.exe_mem_rd_addr != '0) && (rs1_hit || rs2_hit);

    case (state)
      RUN: begin
        if (mem_stall)
          state_nxt = MEM_WAIT;
        else if (mdu_stall)
          state_nxt = MDU_BUSY;
      end
      MEM_WAIT: begin
        if (!mem_stall)
          state_nxt = RUN;
      end
      MDU_BUSY: begin
        // A memory stall seen here holds everything but keeps MDU ownership
        if (bus.mdu_done)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign any_stall = mem_stall || mdu_stall || load_use;
  assign redirect  = bus.exe_branch_taken && !any_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_nxt;
  end

  assign wait_cnt_inc = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};

  // Wait counter only runs while parked in MEM_WAIT without an ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == MEM_WAIT && state_nxt == MEM_WAIT) begin
      if (wait_cnt != TIMEOUT_LIM)
        wait_cnt <= wait_cnt_inc[CNT_W-1:0];
      if (wait_cnt_inc >= {1'b0, TIMEOUT_LIM})
        timeout_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Controls are combinational so a hazard bites in the cycle it appears;
  // gating with rst_n drops them immediately on reset.
  assign bus.pc_stall      = rst_n ? any_stall : `Off;
  assign bus.if_id_stall   = rst_n ? any_stall : `Off;
  assign bus.id_exe_stall  = rst_n ? any_stall : `Off;
  assign bus.exe_mem_stall = rst_n ? mem_stall : `Off;
  // A held MEM stage leaves no room for a bubble in EXE/MEM, so the EXE/MEM
  // bubble only appears for the MDU and load-use cases.
  assign bus.exe_mem_flush = rst_n ? (!mem_stall && (mdu_stall || load_use)) : `Off;
  assign bus.mem_wb_flush  = rst_n ? mem_stall : `Off;
  assign bus.if_id_flush   = rst_n ? redirect : `Off;
  assign bus.id_exe_flush  = rst_n ? redirect : `Off;
  assign bus.pc_redirect   = rst_n ? redirect : `Off;
  assign bus.ctrl_state    = state;
  assign bus.mem_timeout   = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      if (any_stall)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (redirect)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = stall_cycles_q;
  assign bus.perf_flush_cnt    = flush_cnt_q;
`else
  assign bus.perf_stall_cycles = '0;
  assign bus.perf_flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

`timescale 1ns/1ps

module tb_hazard_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, exe_mem_flush,
  //  mem_wb_flush, if_id_flush, id_exe_flush, pc_redirect, ctrl_state, mem_timeout}
  function automatic logic [11:0] outs();
    return {hif.pc_stall, hif.if_id_stall, hif.id_exe_stall, hif.exe_mem_stall,
            hif.exe_mem_flush, hif.mem_wb_flush, hif.if_id_flush, hif.id_exe_flush,
            hif.pc_redirect, hif.ctrl_state, hif.mem_timeout};
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 pipeline running, 1 waiting on memory, 2 MUL/DIV busy
  int          m_mode = 0, n_mode = 0;
  int          m_waits = 0, n_waits = 0;
  bit          m_to = 0, n_to = 0;
  logic [31:0] m_pstall = 0, n_pstall = 0;
  logic [31:0] m_pflush = 0, n_pflush = 0;

  always @(negedge clk) begin : model_cmp
    bit memw, mdub, lu, stall, redir;
    logic [11:0] exp;
    logic [31:0] exp_ps, exp_pf;
    if (rst_n) begin
      memw  = hif.dmem_req && !hif.dmem_ack;
      mdub  = !memw && ((m_mode == 0 && hif.exe_mdu_start && !hif.mdu_done) ||
                        (m_mode == 2 && !hif.mdu_done));
      if (m_mode == 2 && !hif.mdu_done) mdub = 1;
      lu    = !memw && !mdub && hif.exe_mem_mem_re && hif.exe_mem_rd_we &&
              hif.exe_mem_rd_addr != 0 &&
              ((hif.id_exe_rs1_re && hif.id_exe_rs1_addr == hif.exe_mem_rd_addr) ||
               (hif.id_exe_rs2_re && hif.id_exe_rs2_addr == hif.exe_mem_rd_addr));
      stall = memw || mdub || lu;
      redir = hif.exe_branch_taken && !stall;
      exp = {stall, stall, stall, memw, !memw && (mdub || lu), memw,
             redir, redir, redir, 2'(m_mode), m_to};
      check("cycle_outputs", outs(), exp);
`ifdef HAZARD_PERF_CNT_EN
      exp_ps = m_pstall;
      exp_pf = m_pflush;
`else
      exp_ps = 0;
      exp_pf = 0;
`endif
      check("perf_stall", hif.perf_stall_cycles, exp_ps);
      check("perf_flush", hif.perf_flush_cnt, exp_pf);

      case (m_mode)
        0: n_mode <= memw ? 1 : (mdub ? 2 : 0);
        1: n_mode <= memw ? 1 : 0;
        default: n_mode <= hif.mdu_done ? 0 : 2;
      endcase
      // memory waits counted only while already parked and still unacked
      if (m_mode == 1 && memw) begin
        n_waits <= m_waits + 1;
        n_to    <= m_to || (m_waits + 1 >= TO);
      end else begin
        n_waits <= 0;
        n_to    <= m_to;
      end
      n_pstall <= m_pstall + (stall ? 32'd1 : 32'd0);
      n_pflush <= m_pflush + (redir ? 32'd1 : 32'd0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_waits <= 0; m_to <= 0; m_pstall <= 0; m_pflush <= 0;
    end else begin
      m_mode <= n_mode; m_waits <= n_waits; m_to <= n_to;
      m_pstall <= n_pstall; m_pflush <= n_pflush;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hif.id_exe_rs1_addr = 0; hif.id_exe_rs1_re = 0;
    hif.id_exe_rs2_addr = 0; hif.id_exe_rs2_re = 0;
    hif.exe_mem_rd_addr = 0; hif.exe_mem_rd_we = 0; hif.exe_mem_mem_re = 0;
    hif.dmem_req = 0; hif.dmem_ack = 0;
    hif.exe_mdu_start = 0; hif.mdu_done = 0; hif.exe_branch_taken = 0;
  endtask

  task automatic load_in_mem(input logic [4:0] rd, input logic [4:0] rs1, input logic r1e,
                             input logic [4:0] rs2, input logic r2e);
    hif.exe_mem_mem_re = 1; hif.exe_mem_rd_we = 1; hif.exe_mem_rd_addr = rd;
    hif.id_exe_rs1_addr = rs1; hif.id_exe_rs1_re = r1e;
    hif.id_exe_rs2_addr = rs2; hif.id_exe_rs2_re = r2e;
  endtask

  localparam logic [11:0] LU_OUT  = 12'b1110_1000_0000;
  localparam logic [11:0] BR_OUT  = 12'b0000_0011_1000;
  localparam logic [11:0] MEM_RUN = 12'b1111_0100_0000;
  localparam logic [11:0] MEM_WT  = 12'b1111_0100_0010;

  initial begin
    clr();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    #1 check("reset_outs", outs(), 12'h000);
    check("reset_perf", hif.perf_stall_cycles | hif.perf_flush_cnt, 32'd0);

    // load-use on rs1: one stall cycle, then the bubble has moved on
    step(); load_in_mem(5'd5, 5'd5, 1, 5'd0, 0);
    #1 check("lu_rs1", outs(), LU_OUT);
    step(); clr();
    #1 check("lu_release", outs(), 12'h000);
    load_in_mem(5'd0, 5'd0, 1, 5'd0, 1);
    #1 check("lu_rd_zero", outs(), 12'h000);
    load_in_mem(5'd5, 5'd5, 0, 5'd7, 1);
    #1 check("lu_rs1_re_off", outs(), 12'h000);
    load_in_mem(5'd9, 5'd1, 1, 5'd9, 1);
    #1 check("lu_rs2", outs(), LU_OUT);
    step(); clr();

    // plain branch, then branch masked by load-use
    hif.exe_branch_taken = 1;
    #1 check("branch", outs(), BR_OUT);
    step(); load_in_mem(5'd3, 5'd3, 1, 5'd0, 0);
    #1 check("branch_under_lu", outs(), LU_OUT);
    step(); clr();

    // memory access acked after 3 stall cycles
    hif.dmem_req = 1;
    #1 check("mem_c1", outs(), MEM_RUN);
    step(); #1 check("mem_c2", outs(), MEM_WT);
    step(); #1 check("mem_c3", outs(), MEM_WT);
    step(); hif.dmem_ack = 1;
    #1 check("mem_ack", outs(), 12'b0000_0000_0010);
    step(); clr();
    #1 check("mem_after", outs(), 12'h000);

    // MUL/DIV with a taken branch held in EXE
    hif.exe_mdu_start = 1; hif.exe_branch_taken = 1;
    #1 check("mdu_c1", outs(), LU_OUT);
    for (int i = 2; i <= 5; i++) begin
      step(); #1 check("mdu_busy", outs(), 12'b1110_1000_0100);
    end
    step(); hif.mdu_done = 1;
    #1 check("mdu_done_redirect", outs(), 12'b0000_0011_1100);
    step(); clr();
    #1 check("mdu_after", outs(), 12'h000);

    // start and done together: no stall, stays RUN
    hif.exe_mdu_start = 1; hif.mdu_done = 1;
    #1 check("mdu_same_cycle", outs(), 12'h000);
    step(); #1 check("mdu_same_cycle_state", outs(), 12'h000);
    clr();

    // memory stall arriving while MUL/DIV busy
    hif.exe_mdu_start = 1;
    step(); hif.dmem_req = 1;
    #1 check("mem_in_mdu", outs(), 12'b1111_0100_0100);
    step(); #1 check("mem_in_mdu_hold", outs(), 12'b1111_0100_0100);
    hif.dmem_req = 0; hif.mdu_done = 1;
    #1 check("mdu_exit", outs(), 12'b0000_0000_0100);
    step(); clr();

    // timeout: 6 unacked cycles with MEM_TIMEOUT=4
    hif.dmem_req = 1;
    #1 check("to_c1", outs(), MEM_RUN);
    for (int i = 2; i <= 5; i++) begin
      step(); #1 check("to_wait", outs(), MEM_WT);
    end
    step(); #1 check("to_c6", outs(), MEM_WT | 12'h001);
    step(); hif.dmem_ack = 1;
    #1 check("to_ack", outs(), 12'b0000_0000_0011);
    step(); clr();
    #1 check("to_sticky", outs(), 12'h001);
    step(); #1 check("to_sticky2", outs(), 12'h001);

    // asynchronous reset in the middle of a memory wait
    hif.dmem_req = 1;
    step(); step();
    #2 check("pre_reset_state", 32'(hif.ctrl_state), 32'd1);
    rst_n = 0;
    #1 check("async_reset", outs(), 12'h000);
    check("async_reset_perf", hif.perf_stall_cycles | hif.perf_flush_cnt, 32'd0);
    clr();
    step();
    rst_n = 1;
    #1 check("post_reset", outs(), 12'h000);
    step(); step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
